// File: rtl/pwm_bank_if.sv
// pwm_bank_if: register write bus for pwm_bank.
//   wr_en    write strobe, one cycle per write, always accepted
//   wr_addr  0..CHANNELS-1 selects a channel target duty, CHANNELS selects CTRL
//   wr_data  write data (CTRL uses bits [2:0])
// The host side uses the master modport and pwm_bank uses the slave modport.
interface pwm_bank_if #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8
);
  localparam int AW = $clog2(CHANNELS + 1);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank: N-channel PWM generator with a shared prescaler and period counter.
// Each channel has a target duty written over the bus and an active duty that
// is reloaded only when the period counter wraps, so outputs never glitch.
// Optional linear fade moves each active duty one LSB towards its target
// every FADE_DIV periods.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   bus          register write port (pwm_bank_if.slave)
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-clk pulse, the cycle after the period counter wraps to 0
//   fading       high while any active duty differs from its target
module pwm_bank #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 256,
  parameter int FADE_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_bank_if.slave           bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick,
  output logic                fading
);

  localparam int AW  = $clog2(CHANNELS + 1);
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  // CTRL bit positions
  localparam int C_EN   = 0;
  localparam int C_INV  = 1;
  localparam int C_FADE = 2;

  logic [PSW-1:0]      psc_q,  psc_d;
  logic [WIDTH-1:0]    pcnt_q, pcnt_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    tgt_q [CHANNELS];
  logic [WIDTH-1:0]    tgt_d [CHANNELS];
  logic [WIDTH-1:0]    act_q [CHANNELS];
  logic [WIDTH-1:0]    act_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q,  pwm_d;
  logic                ptick_q, ptick_d;
  logic                fading_q, fading_d;

  logic tick;
  logic wrap;
  logic fade_step;
  logic ctrl_sel;

  assign tick      = (psc_q == PSW'(PRESCALE - 1));
  assign wrap      = tick && (pcnt_q == '1);
  assign fade_step = (fcnt_q == FW'(FADE_DIV - 1));
  assign ctrl_sel  = (bus.wr_addr == AW'(CHANNELS));

  // Timebase: prescaler, period counter and fade counter
  always_comb begin
    psc_d  = psc_q;
    pcnt_d = pcnt_q;
    fcnt_d = fcnt_q;
    if (tick) begin
      psc_d  = '0;
      pcnt_d = pcnt_q + WIDTH'(1);
    end else begin
      psc_d  = psc_q + PSW'(1);
    end
    if (wrap) begin
      fcnt_d = fade_step ? '0 : fcnt_q + FW'(1);
    end
  end

  // Register writes; addresses above CHANNELS match nothing and are dropped
  always_comb begin
    tgt_d  = tgt_q;
    ctrl_d = ctrl_q;
    if (bus.wr_en) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (bus.wr_addr == AW'(i)) begin
          tgt_d[i] = bus.wr_data;
        end
      end
      if (ctrl_sel) begin
        ctrl_d = bus.wr_data[2:0];
      end
    end
  end

  // Active duty reload at wrap. Reads the registered targets/CTRL, so a write
  // landing on the wrap edge is picked up at the following wrap.
  always_comb begin
    act_d = act_q;
    if (wrap) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!ctrl_q[C_FADE]) begin
          act_d[i] = tgt_q[i];
        end else if (fade_step) begin
          // Step only towards the target, so it can never overshoot or wrap.
          if (act_q[i] < tgt_q[i]) begin
            act_d[i] = act_q[i] + WIDTH'(1);
          end else if (act_q[i] > tgt_q[i]) begin
            act_d[i] = act_q[i] - WIDTH'(1);
          end
        end
      end
    end
  end

  // Outputs and status flags
  always_comb begin
    pwm_d    = '0;
    fading_d = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (ctrl_q[C_EN] && (pcnt_q < act_q[i])) ^ ctrl_q[C_INV];
      if (act_q[i] != tgt_q[i]) begin
        fading_d = 1'b1;
      end
    end
    ptick_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q    <= '0;
      pcnt_q   <= '0;
      fcnt_q   <= '0;
      ctrl_q   <= 3'b001;
      pwm_q    <= '0;
      ptick_q  <= 1'b0;
      fading_q <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        tgt_q[i] <= '0;
        act_q[i] <= '0;
      end
    end else begin
      psc_q    <= psc_d;
      pcnt_q   <= pcnt_d;
      fcnt_q   <= fcnt_d;
      ctrl_q   <= ctrl_d;
      pwm_q    <= pwm_d;
      ptick_q  <= ptick_d;
      fading_q <= fading_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        tgt_q[i] <= tgt_d[i];
        act_q[i] <= act_d[i];
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = ptick_q;
  assign fading      = fading_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed bench for pwm_bank with CHANNELS=4, WIDTH=4,
// PRESCALE=2, FADE_DIV=2 (one PWM period = 32 clk, duty d -> 2*d clk high).
module tb_pwm_bank;
  localparam int CH = 4;
  localparam int W  = 4;
  localparam int PS = 2;
  localparam int FD = 2;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic          fading;

  pwm_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  pwm_bank #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PS), .FADE_DIV(FD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .fading      (fading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cnt [CH];
  int chg [CH];

  typedef struct packed {
    logic [2:0]      addr;
    logic [3:0]      data;
    logic [3:0][5:0] exp;   // expected high clk count per channel over one period
    logic            fad;
  } vec_t;

  vec_t vt [11];
  int   fexp [13];
  logic ffad [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!period_tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, period_tick}, 32'd1);
  endtask

  // Samples the 32 negedges of one period; call at the negedge where
  // period_tick is high (or one posedge after it).
  task automatic measure();
    logic [CH-1:0] prev;
    prev = '0;
    for (int c = 0; c < CH; c++) begin
      cnt[c] = 0;
      chg[c] = 0;
    end
    for (int s = 0; s < 32; s++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (pwm_out[c] === 1'b1) cnt[c]++;
        if (s > 0 && pwm_out[c] !== prev[c]) chg[c]++;
      end
      prev = pwm_out;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic quiet;

    vt[0]  = '{3'd0, 4'd4,  {6'd0,  6'd0,  6'd0,  6'd8},  1'b0};
    vt[1]  = '{3'd1, 4'd0,  {6'd0,  6'd0,  6'd0,  6'd8},  1'b0};
    vt[2]  = '{3'd2, 4'd15, {6'd0,  6'd30, 6'd0,  6'd8},  1'b0};
    vt[3]  = '{3'd4, 4'd0,  {6'd0,  6'd0,  6'd0,  6'd0},  1'b0};
    vt[4]  = '{3'd4, 4'd2,  {6'd32, 6'd32, 6'd32, 6'd32}, 1'b0};
    vt[5]  = '{3'd4, 4'd3,  {6'd32, 6'd2,  6'd32, 6'd24}, 1'b0};
    vt[6]  = '{3'd4, 4'd1,  {6'd0,  6'd30, 6'd0,  6'd8},  1'b0};
    vt[7]  = '{3'd5, 4'd15, {6'd0,  6'd30, 6'd0,  6'd8},  1'b0};
    vt[8]  = '{3'd3, 4'd1,  {6'd2,  6'd30, 6'd0,  6'd8},  1'b0};
    vt[9]  = '{3'd7, 4'd0,  {6'd2,  6'd30, 6'd0,  6'd8},  1'b0};
    vt[10] = '{3'd3, 4'd0,  {6'd0,  6'd30, 6'd0,  6'd8},  1'b0};

    fexp = '{0, 2, 2, 4, 4, 6, 6, 6, 6, 4, 4, 2, 2};
    ffad = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};

    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_pwm",    {28'd0, pwm_out},  32'd0);
    check("reset_fading", {31'd0, fading},   32'd0);
    check("reset_ptick",  {31'd0, period_tick}, 32'd0);

    // First period_tick 32 clk after release, outputs held low meanwhile
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    quiet = 1'b1;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (pwm_out !== '0) quiet = 1'b0;
      if (period_tick === 1'b1) break;
    end
    check("first_tick_latency", n, 32);
    check("outputs_low_after_reset", {31'd0, quiet}, 32'd1);

    // Table: write, skip to next wrap, measure one full period
    for (int v = 0; v < 11; v++) begin
      wr(vt[v].addr, vt[v].data);
      wait_tick($sformatf("vec%0d_tick", v));
      measure();
      for (int c = 0; c < CH; c++)
        check($sformatf("vec%0d_ch%0d_high", v, c), cnt[c], {26'd0, vt[v].exp[c]});
      check($sformatf("vec%0d_fading", v), {31'd0, fading}, {31'd0, vt[v].fad});
    end

    // Boundary write: ch0=8 on the exact wrap edge (31 clk after the last one)
    repeat (31) @(negedge clk);
    wr(3'd0, 4'd8);
    check("bnd_write_on_wrap", {31'd0, period_tick}, 32'd1);
    @(negedge clk);
    measure();
    check("bnd_old_duty",   cnt[0], 8);
    check("bnd_old_edges",  chg[0], 1);
    check("bnd_ch2_edges",  chg[2], 1);
    measure();
    check("bnd_new_duty",   cnt[0], 16);
    check("bnd_new_edges",  chg[0], 1);
    check("bnd_ch2_high",   cnt[2], 30);

    // Mid-period asynchronous reset with an output high and fading set
    wr(3'd3, 4'd5);
    repeat (3) @(negedge clk);
    check("pre_rst_fading", {31'd0, fading},     32'd1);
    check("pre_rst_ch2",    {31'd0, pwm_out[2]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_pwm",    {28'd0, pwm_out},     32'd0);
    check("midrst_fading", {31'd0, fading},      32'd0);
    check("midrst_ptick",  {31'd0, period_tick}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fade: ch1 0->3, then retarget 0 and mid-fade retarget 1
    wr(3'd4, 4'd5);
    wr(3'd1, 4'd3);
    wait_tick("fade_tick");
    for (int k = 0; k < 13; k++) begin
      if (k == 7) wr(3'd1, 4'd0);
      if (k == 9) wr(3'd1, 4'd1);
      measure();
      check($sformatf("fade%0d_ch1_high", k), cnt[1], fexp[k]);
      check($sformatf("fade%0d_fading", k), {31'd0, fading}, {31'd0, ffad[k]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
